// File: rtl/optical_pkg.sv
// Shared gate-mode encoding and single-bit gate evaluation for the optical gate array.
package optical_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    OPT_AND    = 3'd0,
    OPT_OR     = 3'd1,
    OPT_XOR    = 3'd2,
    OPT_NAND   = 3'd3,
    OPT_NOR    = 3'd4,
    OPT_XNOR   = 3'd5,
    OPT_PASS_A = 3'd6,
    OPT_NOT_A  = 3'd7
  } opt_mode_e;

  function automatic logic opt_gate_eval(opt_mode_e mode, logic a, logic b);
    logic r;
    r = 1'b0;
    case (mode)
      OPT_AND:    r = a & b;
      OPT_OR:     r = a | b;
      OPT_XOR:    r = a ^ b;
      OPT_NAND:   r = ~(a & b);
      OPT_NOR:    r = ~(a | b);
      OPT_XNOR:   r = ~(a ^ b);
      OPT_PASS_A: r = a;
      OPT_NOT_A:  r = ~a;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/optical_threshold_detector.sv
// Converts one unsigned intensity sample into a logic level against a threshold.
module optical_threshold_detector #(
  parameter int INTENSITY_W = 8
) (
  input  logic [INTENSITY_W-1:0] intensity,
  input  logic [INTENSITY_W-1:0] threshold,
  output logic                   det
);

  // A zero threshold makes every sample detect as 1.
  assign det = (intensity >= threshold);

endmodule

// File: rtl/optical_gate_array.sv
// CHANNELS-wide optical gate array: detect, gate at stage 0, then carry {valid, y, mode}
// through a stall-on-backpressure pipeline of LATENCY registers.
module optical_gate_array
  import optical_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int INTENSITY_W = 8,
  parameter int LATENCY     = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CHANNELS*INTENSITY_W-1:0] in_a,
  input  logic [CHANNELS*INTENSITY_W-1:0] in_b,
  input  logic [MODE_W-1:0]               in_mode,
  input  logic [INTENSITY_W-1:0]          threshold,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CHANNELS-1:0]             out_y,
  output logic [MODE_W-1:0]               out_mode,
  output logic [15:0]                     beat_count
);

  localparam int SW = 1 + CHANNELS + MODE_W;

  logic [CHANNELS-1:0] det_a;
  logic [CHANNELS-1:0] det_b;
  logic [CHANNELS-1:0] gate_y;
  logic [SW-1:0]       stg_in;
  logic                advance;
  logic [15:0]         beat_count_d;
  logic [15:0]         beat_count_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_det
    optical_threshold_detector #(.INTENSITY_W(INTENSITY_W)) u_det_a (
      .intensity (in_a[ch*INTENSITY_W +: INTENSITY_W]),
      .threshold (threshold),
      .det       (det_a[ch])
    );
    optical_threshold_detector #(.INTENSITY_W(INTENSITY_W)) u_det_b (
      .intensity (in_b[ch*INTENSITY_W +: INTENSITY_W]),
      .threshold (threshold),
      .det       (det_b[ch])
    );
  end

  // Stage 0 input: bubbles enter as all-zero so no stale y/mode ever travels.
  always_comb begin
    gate_y = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      gate_y[k] = opt_gate_eval(opt_mode_e'(in_mode), det_a[k], det_b[k]);
    end
    stg_in = in_valid ? {1'b1, gate_y, in_mode} : '0;
  end

  for (genvar s = 0; s < LATENCY; s++) begin : g_stg
    logic [SW-1:0] stg_d;
    logic [SW-1:0] stg_q;

    if (s == 0) begin : g_head
      always_comb stg_d = advance ? stg_in : stg_q;
    end else begin : g_body
      always_comb stg_d = advance ? g_stg[s-1].stg_q : stg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) stg_q <= '0;
      else     stg_q <= stg_d;
    end
  end

  assign out_valid = g_stg[LATENCY-1].stg_q[SW-1];
  assign out_y     = g_stg[LATENCY-1].stg_q[SW-2 -: CHANNELS];
  assign out_mode  = g_stg[LATENCY-1].stg_q[MODE_W-1:0];

  // The whole pipeline, bubbles included, freezes while the result is held.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    beat_count_d = beat_count_q;
    if (out_valid && out_ready) beat_count_d = beat_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_count_q <= '0;
    else     beat_count_q <= beat_count_d;
  end

  assign beat_count = beat_count_q;

endmodule

// File: doc/optical_gate_array.md
# optical_gate_array

Parametrised, pipelined successor to the single-bit optical AND/OR gates. It accepts per-channel optical intensity samples on two beams, A and B. Each sample is thresholded to a logic level, combined per a runtime-selected gate mode, and delivered after a fixed modelled propagation latency. Input and output use valid/ready handshakes. The block sits between the photodetector front-end model and downstream optical-logic consumers, replacing per-gate instances with one CHANNELS-wide array.

## Interface
- CHANNELS, 4: number of independent gate channels (≥1)
- INTENSITY_W, 8: bits per intensity sample (≥2)
- LATENCY, 3: pipeline stages from input acceptance to output (≥1)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  CHANNELS*INTENSITY_W  beam A intensities, channel k at [k*INTENSITY_W +: INTENSITY_W]
- in_b  in  CHANNELS*INTENSITY_W  beam B intensities, same packing
- in_mode  in  3  gate mode, sampled with the beat
- threshold  in  INTENSITY_W  detection threshold, sampled with the beat
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts the result
- out_y  out  CHANNELS  per-channel logic result
- out_mode  out  3  mode the result was computed with
- beat_count  out  16  completed output transfers, wraps at 2^16

## Operation
- Detection: a channel bit is 1 iff intensity ≥ threshold, unsigned. threshold=0 means every bit is 1.
- Modes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS_A, 7 NOT_A. PASS_A and NOT_A ignore B.
- Detection and gate evaluation both happen at stage 0 on acceptance. Stages 1..LATENCY-1 only carry {valid, y, mode}.
- Acceptance: a beat transfers on a rising edge where in_valid && in_ready.
- Output transfer: occurs on a rising edge where out_valid && out_ready. beat_count increments by 1 on each transfer and wraps from 0xFFFF to 0x0000.
- Stall: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance=0, the whole pipeline holds, including bubbles. No bubble compression.
  - out_y and out_mode stay stable while out_valid && !out_ready.
- mode and threshold are captured per beat. Changing them mid-stream affects only later beats.
- in_valid=1 while in_ready=0 has no effect. The source must hold the beat.

## Timing
- Reset values: all stage valid bits 0, out_valid 0, out_y 0, out_mode 0, beat_count 0.
- in_ready is 1 during and after reset, since out_valid=0.
- Latency: a beat accepted at edge N drives out_valid=1 after edge N+LATENCY-1, provided no stall occurs. For LATENCY=1, the output is registered directly at the acceptance edge.
- Throughput: one beat per cycle while out_ready=1.
- A simultaneous output transfer and input acceptance in the same cycle is legal and required for full throughput.
- Reset asserted mid-operation: all in-flight beats are discarded immediately (asynchronously). beat_count clears. No partial output is ever presented.
- out_ready deasserted for K cycles at full load: exactly K cycles of in_ready=0, with no loss and no duplication.

## Structure
- Package optical_pkg holds:
  - the mode enum (OPT_AND..OPT_NOT_A, 3 bits)
  - a function opt_gate_eval(mode, a, b) returning one bit
  - the MODE_W=3 constant
- Sub-module optical_threshold_detector: a per-channel comparator (intensity, threshold → bit), instantiated 2*CHANNELS times via generate.
- The pipeline is a generated array of LATENCY registers inside the top level.

## Test plan
- Truth table: CHANNELS=4, threshold=0x80. Channels carry A/B = {0x00/0x00, 0x00/0xFF, 0xFF/0x00, 0xFF/0xFF}. With mode 0, out_y=4'b1000 (channel 0 at bit 0). With mode 1, out_y=4'b1110. With mode 2, out_y=4'b0110. Each result arrives exactly LATENCY cycles after acceptance.
- Threshold boundary: A=0x7F gives 0 and A=0x80 gives 1 at threshold 0x80, mode PASS_A. threshold=0 gives all 1s in mode AND.
- Backpressure: stream 10 beats with out_ready=0 for cycles 4–7. Output sequence equals input order, out_y stays stable while stalled, in_ready=0 for exactly those cycles, and beat_count=10 at the end.
- Per-beat mode: alternate modes AND/NOR on consecutive beats with fixed data. Each out_mode and out_y matches its own beat.
- Reset mid-flight: accept 2 beats, then pulse rst between clock edges. out_valid=0 and beat_count=0 immediately, and no stale beat appears afterward.
- Counter wrap: preload via 65536 transfers, or force beat_count near 0xFFFF if the bench supports it. The next transfer gives 0x0000.
